// File: rtl/alu_wb_buffer.sv
// ALU result buffer: in-order circular FIFO feeding the writeback port.
// Optional ALU_WB_BYPASS_EN forwards a result straight through when empty.
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
  input  logic                     alu_branch_res_i,
  output logic                     alu_ready_o,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_branch_res_o,
  input  logic                     wb_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     branch_res;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            buf_valid;
  logic            bypass;
  logic            push;
  logic            pop;

  assign in_entry.result     = alu_result_i;
  assign in_entry.trans_id   = alu_trans_id_i;
  assign in_entry.branch_res = alu_branch_res_i;

  assign buf_valid   = (count != '0);
  assign alu_ready_o = (count != CW'(DEPTH));

`ifdef ALU_WB_BYPASS_EN
  assign bypass = !buf_valid & alu_valid_i
                & wb_ready_i & !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result is consumed directly and never occupies a slot.
  assign push = alu_valid_i & alu_ready_o
              & !flush_i & !bypass;
  assign pop  = buf_valid & wb_ready_i & !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (alu_valid_i & !alu_ready_o)
        overflow_o <= 1'b1;
    end
  end

  always_comb begin
    head = '0;
    unique case (1'b1)
      bypass:    head = in_entry;
      buf_valid: head = mem[rd_ptr];
      default:   head = '0;
    endcase
  end

  assign wb_valid_o      = buf_valid | bypass;
  assign wb_result_o     = head.result;
  assign wb_trans_id_o   = head.trans_id;
  assign wb_branch_res_o = head.branch_res;
  assign count_o         = count;

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Result buffer directly downstream of the ALU, in the execute stage.
- Captures ALU results (result, trans_id, branch result) with a valid/ready handshake.
- Holds them in a small in-order circular FIFO and presents them to the writeback/commit port.
- Decouples ALU issue from writeback-port arbitration stalls and supports pipeline flush.

Parameters:
- XLEN, 64, data width of result (matches riscv::xlen_t).
- TRANS_ID_BITS, 3, width of scoreboard transaction ID.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  discard all buffered and incoming results
- alu_valid_i  in  1  ALU result valid
- alu_result_i  in  XLEN  ALU result_o
- alu_trans_id_i  in  TRANS_ID_BITS  trans ID of the result
- alu_branch_res_i  in  1  ALU alu_branch_res_o
- alu_ready_o  out  1  buffer can accept a result this cycle
- wb_valid_o  out  1  head entry valid
- wb_result_o  out  XLEN  head result
- wb_trans_id_o  out  TRANS_ID_BITS  head trans ID
- wb_branch_res_o  out  1  head branch result
- wb_ready_i  in  1  writeback consumes head this cycle
- count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: push attempted while not ready

Behaviour:
- Single clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset: rd_ptr, wr_ptr and count = 0; wb_valid_o = 0; overflow_o = 0; alu_ready_o = 1.
- Entry storage does not need reset. wb_result_o, wb_trans_id_o and wb_branch_res_o read 0 while empty; gate them with valid.
- push = alu_valid_i & alu_ready_o & !flush_i. Writes mem[wr_ptr]; wr_ptr advances modulo DEPTH.
- pop = wb_valid_o & wb_ready_i & !flush_i. rd_ptr advances modulo DEPTH.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- alu_ready_o = (count != DEPTH). Registered-state only; no combinational path from wb_ready_i.
  - When full with a pop in the same cycle, no push is accepted that cycle.
  - The freed slot is offered on the next cycle.
- wb_valid_o = (count != 0). wb_* are driven from mem[rd_ptr].
- Latency: a result pushed in cycle N is visible on wb_* in cycle N+1.
- Strict in-order delivery; wrap-around of both pointers is transparent.
- Data on wb_* stays stable while wb_valid_o & !wb_ready_i.
- Overflow: alu_valid_i & !alu_ready_o & !flush_i sets overflow_o on the next edge.
  - The result is dropped.
  - overflow_o is cleared only by flush_i or reset.
- Flush, synchronous:
  - In the flush cycle, push and pop are suppressed.
  - Next cycle: count = 0, pointers = 0, wb_valid_o = 0, overflow_o = 0.
  - A flush in the same cycle as alu_valid_i discards that result.
- Reset mid-operation: immediate (asynchronous) return to reset state; buffered results are lost.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined:
  - When count == 0, alu_valid_i = 1, wb_ready_i = 1 and !flush_i, the incoming result drives wb_* combinationally in the same cycle with wb_valid_o = 1.
  - The entry is not stored; count stays 0.
  - If wb_ready_i = 0 while empty, the result is stored normally; wb_valid_o follows from the buffer.
  - alu_ready_o is unchanged in both cases. Ordering is preserved because bypass only applies when empty.
- Undefined: no combinational path from alu_* to wb_*; minimum latency is 1 cycle.

Test Plan:
- Basic, single result: reset, then push result=64'h3, id=2, branch=0 with wb_ready_i=1 -> next cycle wb_valid_o=1, wb_result_o=3, wb_trans_id_o=2; count_o returns to 0 after the pop.
- Fill and overflow: wb_ready_i=0, push ids 0..3 -> count_o=4, alu_ready_o=0. A 5th push -> overflow_o=1, count_o stays 4. Then wb_ready_i=1 -> ids pop in order 0,1,2,3.
- Wrap-around: continuous push/pop at 1 per cycle for 10 results (id = i mod 8, result = i) -> outputs in order, count_o constant at 1, pointers wrap without loss.
- Full with simultaneous push/pop: full, wb_ready_i=1, alu_valid_i=1 -> pop accepted, push rejected (alu_ready_o=0). Next cycle alu_ready_o=1 and the push is accepted; count_o 4 -> 3 -> 4.
- Flush: 3 entries buffered, overflow_o set; assert flush_i together with alu_valid_i -> next cycle count_o=0, wb_valid_o=0, overflow_o=0. The incoming result is never seen on wb_*.
- Async reset and bypass:
  - Drop rst_ni mid-stream with 2 entries buffered -> wb_valid_o=0 immediately, without waiting for a clock edge.
  - With ALU_WB_BYPASS_EN, empty buffer, push result=64'hA and wb_ready_i=1 -> wb_valid_o=1, wb_result_o=A in the same cycle, count_o=0.
